// File: rtl/univ_reg_if.sv
// Handshake-free operand bus for univ_reg.
// The master drives the op controls; the slave returns register state.
interface univ_reg_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_;
    logic             co;
    logic             zero;

    modport master (
        output en,
        output mode,
        output d,
        output sin,
        input  q,
        input  q_,
        input  co,
        input  zero
    );

    modport slave (
        input  en,
        input  mode,
        input  d,
        input  sin,
        output q,
        output q_,
        output co,
        output zero
    );
endinterface

// File: rtl/univ_reg.sv
// Universal register: hold/load/shift/rotate/inc/dec/clear.
// Registered carry-out and zero flags; async active-high reset.
module univ_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic        clk,
    input logic        rst,
    univ_reg_if.slave  bus
);
    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_INC  = 3'b100,
        M_DEC  = 3'b101,
        M_ROL  = 3'b110,
        M_CLR  = 3'b111
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             co_r;
    logic             co_nxt;
    logic             zero_r;
    logic [WIDTH:0]   inc_w;
    logic [WIDTH:0]   dec_w;

    assign mode = mode_e'(bus.mode);

    // Extra MSB captures carry out of inc and borrow out of dec.
    assign inc_w = {1'b0, q_r} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_w = {1'b0, q_r} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        q_nxt  = q_r;
        co_nxt = co_r;
        if (bus.en) begin
            unique case (mode)
                M_HOLD: begin
                    q_nxt  = q_r;
                    co_nxt = co_r;
                end
                M_LOAD: begin
                    q_nxt  = bus.d;
                    co_nxt = 1'b0;
                end
                M_SHL: begin
                    q_nxt  = {q_r[WIDTH-2:0], bus.sin};
                    co_nxt = q_r[WIDTH-1];
                end
                M_SHR: begin
                    q_nxt  = {bus.sin, q_r[WIDTH-1:1]};
                    co_nxt = q_r[0];
                end
                M_INC: begin
                    q_nxt  = inc_w[WIDTH-1:0];
                    co_nxt = inc_w[WIDTH];
                end
                M_DEC: begin
                    q_nxt  = dec_w[WIDTH-1:0];
                    co_nxt = dec_w[WIDTH];
                end
                M_ROL: begin
                    q_nxt  = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                    co_nxt = q_r[WIDTH-1];
                end
                M_CLR: begin
                    q_nxt  = '0;
                    co_nxt = 1'b0;
                end
            endcase
        end
    end

    // zero tracks the value being written so it never lags q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= RST_VAL;
            co_r   <= 1'b0;
            zero_r <= (RST_VAL == '0);
        end else begin
            q_r    <= q_nxt;
            co_r   <= co_nxt;
            zero_r <= (q_nxt == '0);
        end
    end

    assign bus.q    = q_r;
    assign bus.q_   = ~q_r;
    assign bus.co   = co_r;
    assign bus.zero = zero_r;
endmodule

// File: tb/tb_univ_reg.sv
// Directed vector table, reset corner cases and a random
// run against an independent next-state model.
module tb_univ_reg;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    univ_reg_if #(.WIDTH(8)) bus ();

    univ_reg #(
        .WIDTH  (8),
        .RST_VAL(8'h5A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sin;
        logic [7:0] eq;
        logic       eco;
        logic       ez;
        string      nm;
    } vec_t;

    vec_t tbl[22];

    task automatic check_state(input string nm, input logic [7:0] eq,
                               input logic eco, input logic ez);
        logic [7:0] eqn;
        eqn = ~eq;
        checks++;
        if (bus.q !== eq || bus.q_ !== eqn || bus.co !== eco || bus.zero !== ez) begin
            errors++;
            $display("FAIL %s: got q=%h q_=%h co=%b zero=%b, want q=%h q_=%h co=%b zero=%b",
                     nm, bus.q, bus.q_, bus.co, bus.zero, eq, eqn, eco, ez);
        end
    endtask

    task automatic drive(input logic en, input logic [2:0] mode,
                         input logic [7:0] d, input logic sin);
        bus.en   = en;
        bus.mode = mode;
        bus.d    = d;
        bus.sin  = sin;
    endtask

    // Reference model written arithmetically, independent of the RTL slicing.
    task automatic model(input logic [7:0] q, input logic co, input logic en,
                         input logic [2:0] mode, input logic [7:0] d, input logic sin,
                         output logic [7:0] nq, output logic nco);
        int v;
        v   = int'(q);
        nq  = q;
        nco = co;
        if (en) begin
            case (mode)
                3'd1: begin nq = d; nco = 1'b0; end
                3'd2: begin nco = (v >= 128); nq = 8'((v * 2) % 256 + int'(sin)); end
                3'd3: begin nco = (v % 2 == 1); nq = 8'(v / 2 + (sin ? 128 : 0)); end
                3'd4: begin nco = (v == 255); nq = 8'((v + 1) % 256); end
                3'd5: begin nco = (v == 0); nq = 8'((v + 255) % 256); end
                3'd6: begin nco = (v >= 128); nq = 8'((v * 2) % 256 + (v >= 128 ? 1 : 0)); end
                3'd7: begin nq = 8'h00; nco = 1'b0; end
                default: begin nq = q; nco = co; end
            endcase
        end
    endtask

    initial begin
        logic [7:0] mq;
        logic       mco;
        logic [7:0] nq;
        logic       nco;
        logic       ren;
        logic [2:0] rmode;
        logic [7:0] rd;
        logic       rsin;

        errors = 0;
        checks = 0;

        tbl[0]  = '{1'b1, 3'd1, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, "load_ff"};
        tbl[1]  = '{1'b1, 3'd4, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, "inc_wrap"};
        tbl[2]  = '{1'b1, 3'd5, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, "dec_borrow"};
        tbl[3]  = '{1'b1, 3'd5, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, "dec_plain"};
        tbl[4]  = '{1'b1, 3'd1, 8'h81, 1'b1, 8'h81, 1'b0, 1'b0, "load_81"};
        tbl[5]  = '{1'b1, 3'd2, 8'hAA, 1'b0, 8'h02, 1'b1, 1'b0, "shl_sin0"};
        tbl[6]  = '{1'b1, 3'd3, 8'hAA, 1'b1, 8'h81, 1'b0, 1'b0, "shr_sin1"};
        tbl[7]  = '{1'b1, 3'd6, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0, "rol"};
        tbl[8]  = '{1'b1, 3'd1, 8'h9E, 1'b0, 8'h9E, 1'b0, 1'b0, "load_9e"};
        tbl[9]  = '{1'b1, 3'd2, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b0, "shl_to_3c"};
        tbl[10] = '{1'b0, 3'd1, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b0, "en0_load_a"};
        tbl[11] = '{1'b0, 3'd1, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b0, "en0_load_b"};
        tbl[12] = '{1'b0, 3'd1, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b0, "en0_load_c"};
        tbl[13] = '{1'b0, 3'd7, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b0, "en0_clr"};
        tbl[14] = '{1'b1, 3'd7, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, "sync_clr"};
        tbl[15] = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, "hold_zero"};
        tbl[16] = '{1'b1, 3'd5, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, "dec_from_0"};
        tbl[17] = '{1'b1, 3'd0, 8'h12, 1'b1, 8'hFF, 1'b1, 1'b0, "hold_co"};
        tbl[18] = '{1'b1, 3'd3, 8'h00, 1'b0, 8'h7F, 1'b1, 1'b0, "shr_sin0"};
        tbl[19] = '{1'b1, 3'd4, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0, "inc_7f"};
        tbl[20] = '{1'b1, 3'd6, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, "rol_80"};
        tbl[21] = '{1'b1, 3'd2, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0, "shl_sin1"};

        rst = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        #1;
        check_state("reset_state", 8'h5A, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sin);
            @(posedge clk);
            #1;
            check_state(tbl[i].nm, tbl[i].eq, tbl[i].eco, tbl[i].ez);
        end

        @(negedge clk);
        drive(1'b1, 3'd1, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check_state("load_00", 8'h00, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_state("async_rst", 8'h5A, 1'b0, 1'b0);

        @(negedge clk);
        drive(1'b1, 3'd4, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check_state("rst_holds", 8'h5A, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_state("first_inc", 8'h5B, 1'b0, 1'b0);

        mq  = 8'h5B;
        mco = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            ren   = ($urandom_range(0, 7) != 0);
            rmode = 3'($urandom_range(0, 7));
            rd    = 8'($urandom_range(0, 255));
            rsin  = 1'($urandom_range(0, 1));
            if (n % 50 == 0) rd = 8'h00;
            if (n % 50 == 1) rd = 8'hFF;
            drive(ren, rmode, rd, rsin);
            model(mq, mco, ren, rmode, rd, rsin, nq, nco);
            mq  = nq;
            mco = nco;
            @(posedge clk);
            #1;
            check_state("random", mq, mco, (mq == 8'h00));
            checks++;
            if (bus.zero !== (bus.q == 8'h00)) begin
                errors++;
                $display("FAIL zero_invariant: zero=%b with q=%h", bus.zero, bus.q);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/univ_reg.md
Name: univ_reg

Overview:
- Parametrised successor to the single-bit reset flip-flop.
- Holds a WIDTH-bit register with a selectable per-cycle operation: hold, parallel load, shift, rotate, increment, decrement or synchronous clear.
- Produces registered carry/shift-out and zero flags.
- Used in the CPU datapath as the accumulator, shift register and program-counter building block.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- RST_VAL, 0, value loaded into q on reset (WIDTH bits; only the low WIDTH bits are used).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- en  input  1  operation enable; 0 forces hold
- mode  input  3  operation select (see Behaviour)
- d  input  WIDTH  parallel load data
- sin  input  1  serial input for shift operations
- q  output  WIDTH  register contents
- q_  output  WIDTH  bitwise complement of q (~q); never equal to q
- co  output  1  registered carry / borrow / shifted-out bit
- zero  output  1  registered flag, 1 when q == 0

Behaviour:
- Interface: one clock, clk. Reset is rst, asynchronous and active-high.
- Reset:
  - rst=1 immediately (no clock edge needed) forces q=RST_VAL, co=0, zero=(RST_VAL==0).
  - While rst=1, all inputs are ignored.
  - Deassertion is sampled at the next rising clk. The first operation executes on the first rising edge with rst=0.
- Reset mid-operation: rst asserted at any point discards the in-flight operation. There is no partial update.
- Latency and timing:
  - All state updates occur on the rising clk edge; latency is 1 cycle from input sample to q/co/zero.
  - q_ is combinational from q, with zero delay relative to q.
- en=0: q, co and zero all hold, regardless of mode, d or sin.
- en=1, per mode (q' = next q, co' = next co):
  - 000 hold: q'=q, co'=co.
  - 001 load: q'=d, co'=0.
  - 010 shift left: q'={q[WIDTH-2:0],sin}, co'=q[WIDTH-1].
  - 011 shift right: q'={sin,q[WIDTH-1:1]}, co'=q[0].
  - 100 increment: q'=q+1 modulo 2^WIDTH, co'=1 iff q was all ones (wraps to 0).
  - 101 decrement: q'=q-1 modulo 2^WIDTH, co'=1 iff q was 0 (borrow; wraps to all ones).
  - 110 rotate left: q'={q[WIDTH-2:0],q[WIDTH-1]}, co'=q[WIDTH-1]. sin is ignored.
  - 111 sync clear: q'=0, co'=0.
- zero:
  - Registered alongside q, computed from q'.
  - Invariant: zero == (q == 0) on every cycle, including after reset.
- Arithmetic is unsigned. No other flags. No X propagation: mode is fully decoded.
- Simultaneous events: rst has priority over en/mode. en=0 has priority over every mode.

Test Plan:
- WIDTH=8, RST_VAL=8'h5A: assert rst asynchronously between edges -> q=5A and q_=A5 before the next edge, co=0, zero=0. Mid-stream reset after load 8'h00 -> q=5A immediately.
- load d=8'hFF, then increment -> q=00, co=1, zero=1. Then decrement -> q=FF, co=1, zero=0. Then decrement -> q=FE, co=0.
- From q=8'h81: shift left sin=0 -> q=02, co=1. Shift right sin=1 -> q=81, co=0. Rotate left -> q=03, co=1.
- q=8'h3C, en=0 with mode=001 and d=8'h00 for 3 cycles -> q=3C, co and zero unchanged. Then en=1 mode=111 -> q=00, co=0, zero=1.
- Reset deasserted coincident with en=1 mode=100: first increment occurs on the first rising edge where rst=0 is sampled -> q=RST_VAL+1 one cycle later.
- Exhaustive random run (10k cycles, random en/mode/d/sin) against a reference model -> q, q_, co and zero match every cycle, and zero == (q == 0) always.
